regs_file: RTL and testbench
============================

# regs_file

Integer register file of the core: the responder on the decode-stage register-read interface (address/enable in, data out) and the sink of the write-back port. It holds x1–x31 (x0 hard-wired to zero), serves two combinational read ports to the ID stage and one synchronous write port from WB. It also provides a handshaked debug access port, arbitrated by a small state machine, for halting/inspection logic.

## Interface
Parameters:
- REG_NUM, 32: number of architectural registers; index width is `RADDR_WIDTH.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we_in  in  1  WB write enable (`WRITE_ENABLE active)
- waddr_in  in  `RADDR_WIDTH  WB destination index
- wdata_in  in  `RDATA_WIDTH  WB write data
- reg1_raddr_in  in  `RADDR_WIDTH  read port 1 index (from ID)
- reg1_renable_in  in  1  read port 1 enable (`READ_ENABLE active)
- reg1_rdata_out  out  `RDATA_WIDTH  read port 1 data (to ID)
- reg2_raddr_in / reg2_renable_in / reg2_rdata_out: same as port 1
- dbg_req_in  in  1  debug request, held until ack seen
- dbg_we_in  in  1  1 = debug write, 0 = debug read
- dbg_addr_in  in  `RADDR_WIDTH  debug register index
- dbg_wdata_in  in  `RDATA_WIDTH  debug write data
- dbg_ack_out  out  1  one-cycle completion pulse
- dbg_rdata_out  out  `RDATA_WIDTH  debug read result, valid while ack high and held until next debug read completes

## Operation
- Reset (rst_n low, asynchronous): all registers cleared to `ZERO; FSM to IDLE; dbg_ack_out = 0; dbg_rdata_out = `ZERO. Read outputs therefore read `ZERO during reset.
- Read ports (combinational): rdata = `ZERO if renable inactive or raddr == `ZERO_REG; otherwise register content (see bypass under Configuration).
- WB write: at rising edge, if we_in active and waddr_in != `ZERO_REG, reg[waddr_in] <= wdata_in. Writes to x0 are discarded.
- Debug FSM states:
  - IDLE: dbg_req_in = 1 -> ACCESS.
  - ACCESS: if dbg_we_in = 1 and we_in active -> stay (WB has priority; stall). Otherwise perform the access at this edge: write reg[dbg_addr_in] <= dbg_wdata_in (ignored for x0), or capture dbg_rdata_out <= read value of dbg_addr_in (x0 -> `ZERO); -> DONE.
  - DONE: dbg_ack_out = 1; -> IDLE unconditionally.
- Requester rule: addr/we/wdata stable from req rise through ack; req deasserted in the cycle after ack is sampled high.
- Debug read in ACCESS never stalls, even when WB writes in the same cycle.

## Timing
- Read ports: zero latency (same cycle).
- WB write: visible on read ports the next cycle (same cycle if bypass compiled in).
- Debug: req high in cycle 0 -> ACCESS cycle 1 -> ack high in cycle 2 (minimum); each stalled ACCESS cycle adds one cycle.
- dbg_ack_out is decoded from registered state: glitch-free, high exactly one cycle per request.
- Reset asserted mid-transaction: transaction aborted, no ack issued, no partial write; the requester must re-issue after reset.

## Configuration
- REGS_BYPASS_EN defined: when we_in active, waddr_in != `ZERO_REG and waddr_in == raddr of an enabled read port, that port returns wdata_in in the same cycle; a debug read in ACCESS with the same match captures wdata_in.
- Undefined: read ports and debug read return array content only (pre-write value in the write cycle); the pipeline must stall one cycle on such hazards.

## Structure
- In defines.v: `RADDR_WIDTH, `RDATA_WIDTH, `REG_NUM, `ZERO_REG, `ZERO, `READ_ENABLE/`READ_DISABLE, `WRITE_ENABLE/`WRITE_DISABLE, and the debug FSM state encodings (DBG_IDLE, DBG_ACCESS, DBG_DONE).
- One sub-module: regs_dbg_port (FSM, ack generation, dbg_rdata_out register); it outputs a one-cycle debug-write strobe and debug read-capture strobe to the array in regs_file.

## Test plan
- Reset: write x5 = 0x1234_5678, pulse rst_n low -> reg1 read of x5 returns 0x0, dbg_ack_out = 0, dbg_rdata_out = 0x0.
- x0: WB write x0 = 0xFFFF_FFFF, debug write x0 = 0xA5A5_A5A5 -> reads of x0 on both ports and via debug return 0x0.
- Read enable: x7 = 0xDEAD_BEEF, reg2_raddr = 7 with renable inactive -> reg2_rdata_out = 0x0; active -> 0xDEAD_BEEF.
- Bypass: reg1 reads x3 (old 0x1) while WB writes x3 = 0x55 same cycle -> 0x55 with REGS_BYPASS_EN, 0x1 without; both read 0x55 next cycle.
- Debug write stall: debug write x9 = 0xCAFE_0000 while we_in held active 3 cycles -> ack in cycle 5 (2 + 3 stall), x9 = 0xCAFE_0000 afterward, WB writes all land.
- Debug read + reset abort: debug read x4 = 0x42 -> ack cycle 2, dbg_rdata_out = 0x42; second request with rst_n pulsed low during ACCESS -> no ack, FSM IDLE.

Source files
------------

// File: rtl/regs_file_pkg.sv
// regs_file_pkg: shared widths, constants and debug FSM states
// for the integer register file (regs_file, regs_dbg_port).
package regs_file_pkg;

   localparam int RADDR_WIDTH = 5;
   localparam int RDATA_WIDTH = 32;
   localparam int REGS_NUM    = 32;

   localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
   localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;

   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      DBG_IDLE   = 2'd0,
      DBG_ACCESS = 2'd1,
      DBG_DONE   = 2'd2
   } dbg_state_e;

endpackage

// File: rtl/regs_file_dbg_port.sv
// regs_dbg_port: debug access FSM, ack pulse and read-result register.
// Emits one-cycle write/capture strobes toward the register array.
module regs_dbg_port
   import regs_file_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req,
   input  logic                   we,
   input  logic                   wb_we,
   input  logic [RDATA_WIDTH-1:0] rd_value,
   output logic                   ack,
   output logic [RDATA_WIDTH-1:0] rdata,
   output logic                   wr_stb,
   output logic                   rd_stb
);

   dbg_state_e state;
   dbg_state_e state_nxt;

   // state register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DBG_IDLE;
      else        state <= state_nxt;
   end

   // next state and strobes; a debug write yields to a WB write
   always_comb begin
      state_nxt = state;
      wr_stb    = 1'b0;
      rd_stb    = 1'b0;
      unique case (state)
         DBG_IDLE: begin
            if (req) state_nxt = DBG_ACCESS;
         end
         DBG_ACCESS: begin
            if (!we) begin
               rd_stb    = 1'b1;
               state_nxt = DBG_DONE;
            end else if (wb_we == WRITE_DISABLE) begin
               wr_stb    = 1'b1;
               state_nxt = DBG_DONE;
            end
         end
         DBG_DONE: state_nxt = DBG_IDLE;
         default:  state_nxt = DBG_IDLE;
      endcase
   end

   // ack comes straight from the state flop so it cannot glitch
   assign ack = (state == DBG_DONE);

   // read result is held until the next debug read completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rdata <= ZERO;
      else if (rd_stb) rdata <= rd_value;
   end

endmodule

// File: rtl/regs_file.sv
// regs_file: x0..x31 integer registers, two combinational read ports,
// one WB write port and a debug port. Optional macro: REGS_BYPASS_EN.
module regs_file
   import regs_file_pkg::*;
#(
   parameter int REG_NUM = REGS_NUM
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we_in,
   input  logic [RADDR_WIDTH-1:0] waddr_in,
   input  logic [RDATA_WIDTH-1:0] wdata_in,
   input  logic [RADDR_WIDTH-1:0] reg1_raddr_in,
   input  logic                   reg1_renable_in,
   output logic [RDATA_WIDTH-1:0] reg1_rdata_out,
   input  logic [RADDR_WIDTH-1:0] reg2_raddr_in,
   input  logic                   reg2_renable_in,
   output logic [RDATA_WIDTH-1:0] reg2_rdata_out,
   input  logic                   dbg_req_in,
   input  logic                   dbg_we_in,
   input  logic [RADDR_WIDTH-1:0] dbg_addr_in,
   input  logic [RDATA_WIDTH-1:0] dbg_wdata_in,
   output logic                   dbg_ack_out,
   output logic [RDATA_WIDTH-1:0] dbg_rdata_out
);

   logic [RDATA_WIDTH-1:0] regs [REG_NUM];
   logic [RDATA_WIDTH-1:0] dbg_rd_value;
   logic                   dbg_wr_stb;
   logic                   dbg_rd_stb;
   logic                   wb_act;

   assign wb_act = (we_in == WRITE_ENABLE);

   regs_dbg_port u_dbg (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (dbg_req_in),
      .we       (dbg_we_in),
      .wb_we    (we_in),
      .rd_value (dbg_rd_value),
      .ack      (dbg_ack_out),
      .rdata    (dbg_rdata_out),
      .wr_stb   (dbg_wr_stb),
      .rd_stb   (dbg_rd_stb)
   );

   // array update; WB and debug writes never coincide (debug stalls)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO;
      end else if (wb_act && waddr_in != ZERO_REG) begin
         regs[waddr_in] <= wdata_in;
      end else if (dbg_wr_stb && dbg_addr_in != ZERO_REG) begin
         regs[dbg_addr_in] <= dbg_wdata_in;
      end
   end

   // read port 1
   always_comb begin
      reg1_rdata_out = ZERO;
      if (reg1_renable_in == READ_ENABLE &&
          reg1_raddr_in != ZERO_REG) begin
         reg1_rdata_out = regs[reg1_raddr_in];
`ifdef REGS_BYPASS_EN
         if (wb_act && waddr_in == reg1_raddr_in)
            reg1_rdata_out = wdata_in;
`endif
      end
   end

   // read port 2
   always_comb begin
      reg2_rdata_out = ZERO;
      if (reg2_renable_in != READ_DISABLE &&
          reg2_raddr_in != ZERO_REG) begin
         reg2_rdata_out = regs[reg2_raddr_in];
`ifdef REGS_BYPASS_EN
         if (wb_act && waddr_in == reg2_raddr_in)
            reg2_rdata_out = wdata_in;
`endif
      end
   end

   // value a debug read would capture at this edge
   always_comb begin
      dbg_rd_value = ZERO;
      if (dbg_addr_in != ZERO_REG) begin
         dbg_rd_value = regs[dbg_addr_in];
`ifdef REGS_BYPASS_EN
         if (wb_act && waddr_in == dbg_addr_in)
            dbg_rd_value = wdata_in;
`endif
      end
   end

endmodule

// File: tb/tb_regs_file.sv
// tb_regs_file: random + directed stimulus, reference register model,
// scoreboard queues drained by a negedge monitor.
module tb_regs_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we_in;
   logic [4:0]  waddr_in;
   logic [31:0] wdata_in;
   logic [4:0]  reg1_raddr_in;
   logic        reg1_renable_in;
   logic [31:0] reg1_rdata_out;
   logic [4:0]  reg2_raddr_in;
   logic        reg2_renable_in;
   logic [31:0] reg2_rdata_out;
   logic        dbg_req_in;
   logic        dbg_we_in;
   logic [4:0]  dbg_addr_in;
   logic [31:0] dbg_wdata_in;
   logic        dbg_ack_out;
   logic [31:0] dbg_rdata_out;

   regs_file dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .we_in           (we_in),
      .waddr_in        (waddr_in),
      .wdata_in        (wdata_in),
      .reg1_raddr_in   (reg1_raddr_in),
      .reg1_renable_in (reg1_renable_in),
      .reg1_rdata_out  (reg1_rdata_out),
      .reg2_raddr_in   (reg2_raddr_in),
      .reg2_renable_in (reg2_renable_in),
      .reg2_rdata_out  (reg2_rdata_out),
      .dbg_req_in      (dbg_req_in),
      .dbg_we_in       (dbg_we_in),
      .dbg_addr_in     (dbg_addr_in),
      .dbg_wdata_in    (dbg_wdata_in),
      .dbg_ack_out     (dbg_ack_out),
      .dbg_rdata_out   (dbg_rdata_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] d1;
      logic [31:0] d2;
   } rd_item_t;

   typedef struct {
      int          cyc;
      bit          rd;
      logic [31:0] d;
   } dbg_item_t;

   rd_item_t    rd_q[$];
   dbg_item_t   dbg_q[$];
   logic [31:0] model [32];
   bit          pw_en;
   logic [4:0]  pw_a;
   logic [31:0] pw_d;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_rd(input bit en, input logic [4:0] a);
      if (!en || a == 5'd0) return 32'h0;
`ifdef REGS_BYPASS_EN
      if (we_in && waddr_in == a) return wdata_in;
`endif
      return model[a];
   endfunction

   task automatic step();
      @(posedge clk);
      if (pw_en && pw_a != 5'd0) model[pw_a] = pw_d;
      pw_en = 0;
      #1;
   endtask

   task automatic drive(input bit we, input logic [4:0] wa,
                        input logic [31:0] wd,
                        input bit e1, input logic [4:0] a1,
                        input bit e2, input logic [4:0] a2);
      we_in = we; waddr_in = wa; wdata_in = wd;
      reg1_renable_in = e1; reg1_raddr_in = a1;
      reg2_renable_in = e2; reg2_raddr_in = a2;
      pw_en = we; pw_a = wa; pw_d = wd;
      rd_q.push_back('{cyc, exp_rd(e1, a1), exp_rd(e2, a2)});
   endtask

   task automatic idle();
      drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
   endtask

   task automatic pulse_reset();
      we_in = 0;
      dbg_req_in = 0;
      rst_n = 0;
      pw_en = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      #2;
      chk("rst_rd1", reg1_rdata_out, 32'h0);
      chk("rst_ack", {31'h0, dbg_ack_out}, 32'h0);
      chk("rst_dbg_rdata", dbg_rdata_out, 32'h0);
      #1 rst_n = 1;
   endtask

   task automatic dbg_op(input bit we, input logic [4:0] a,
                         input logic [31:0] wd, input int nbusy);
      int          c0;
      bit          got;
      logic [4:0]  wa;
      logic [31:0] e;
      idle();
      dbg_req_in = 1; dbg_we_in = we;
      dbg_addr_in = a; dbg_wdata_in = wd;
      c0 = cyc;
      e = (a == 5'd0) ? 32'h0 : model[a];
      dbg_q.push_back('{c0 + 2 + (we ? nbusy : 0), !we, e});
      got = 0;
      for (int i = 1; i < 40; i++) begin
         step();
         if (i <= nbusy) begin
            wa = 5'($urandom_range(1, 31));
            if (wa == a) wa = wa ^ 5'd1;
            drive(1, wa, $urandom, 0, 5'd0, 0, 5'd0);
         end else idle();
         if (dbg_ack_out) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("dbg_timeout", 32'd0, 32'd1);
      step();
      idle();
      dbg_req_in = 0;
      if (we && a != 5'd0) model[a] = wd;
   endtask

   // monitor: drains read and debug scoreboards
   always @(negedge clk) begin
      rd_item_t  r;
      dbg_item_t d;
      while (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
         r = rd_q.pop_front();
         chk("rd1", reg1_rdata_out, r.d1);
         chk("rd2", reg2_rdata_out, r.d2);
      end
      if (rst_n && dbg_ack_out) begin
         if (dbg_q.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
         end else begin
            d = dbg_q.pop_front();
            chk("dbg_ack_cycle", cyc, d.cyc);
            if (d.rd) chk("dbg_rdata", dbg_rdata_out, d.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      pw_en = 0;
      rst_n = 0;
      we_in = 0; waddr_in = 0; wdata_in = 0;
      reg1_raddr_in = 5'd5; reg1_renable_in = 1;
      reg2_raddr_in = 0; reg2_renable_in = 0;
      dbg_req_in = 0; dbg_we_in = 0; dbg_addr_in = 0; dbg_wdata_in = 0;
      #3;
      chk("init_rd1", reg1_rdata_out, 32'h0);
      chk("init_ack", {31'h0, dbg_ack_out}, 32'h0);
      chk("init_dbg_rdata", dbg_rdata_out, 32'h0);
      #14 rst_n = 1;

      // reset clears contents
      step(); drive(1, 5'd5, 32'h1234_5678, 0, 5'd0, 0, 5'd0);
      step(); drive(0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0);
      step(); pulse_reset();
      step(); drive(0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5);

      // x0 is hard-wired
      step(); drive(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd0);
      step(); dbg_op(1, 5'd0, 32'hA5A5_A5A5, 0);
      step(); drive(0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0);
      step(); dbg_op(0, 5'd0, 32'h0, 0);

      // read enable
      step(); drive(1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0);
      step(); drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd7);
      step(); drive(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7);

      // write/read same cycle
      step(); drive(1, 5'd3, 32'h1, 0, 5'd0, 0, 5'd0);
      step(); drive(1, 5'd3, 32'h55, 1, 5'd3, 0, 5'd0);
      step(); drive(0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3);

      // debug write stalled by three WB writes
      step(); dbg_op(1, 5'd9, 32'hCAFE_0000, 3);
      step(); drive(0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd7);

      // debug read, then a read aborted by reset
      step(); drive(1, 5'd4, 32'h42, 0, 5'd0, 0, 5'd0);
      step(); dbg_op(0, 5'd4, 32'h0, 0);
      step(); idle();
      dbg_req_in = 1; dbg_we_in = 0; dbg_addr_in = 5'd4;
      step(); idle();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         step(); idle();
      end
      step(); dbg_op(0, 5'd4, 32'h0, 0);

      // random traffic with occasional debug accesses
      for (int n = 0; n < 400; n++) begin
         step();
         if (n % 50 == 49)
            dbg_op($urandom_range(0, 1), 5'($urandom),
                   $urandom, $urandom_range(0, 3));
         else
            drive($urandom_range(0, 1), 5'($urandom), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom),
                  $urandom_range(0, 3) != 0, 5'($urandom));
      end

      step(); idle();
      step(); idle();
      @(posedge clk); #1;
      chk("rd_q_drained", rd_q.size(), 32'd0);
      chk("dbg_q_drained", dbg_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
